mem_addr_sequencer: RTL and testbench

- Parametrised successor to the two-input PC/ALUResult address multiplexer of the multicycle datapath.
- Selects one of NUM_SRC address sources, registers it, and drives a valid/ready memory port.
- Splits byte, halfword and word accesses that cross a 32-bit word boundary into two aligned beats, with per-beat byte enables.
- Sits between the control FSM (adr_src, req_valid) and unified instruction/data memory.

---
 rtl/mem_addr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_mem_addr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_sequencer.sv
// Purpose: picks one of NUM_SRC addresses, registers it and drives a valid/ready memory port,
//          splitting byte/half/word accesses that cross a 32-bit word into two aligned beats.
// Latency: first beat valid 1 cycle after acceptance; done pulses in the first IDLE cycle after the last beat.
// Backpressure: beat outputs hold while mem_ready is low; req_ready is high only in IDLE.
//
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   src_addr      - NUM_SRC flattened sources (0 = PC, 1 = ALUResult)
//   adr_src       - source select, sampled only when a request is accepted
//   req_size      - 0 byte, 1 half, 2/3 word
//   req_valid     - request strobe; req_ready high only in IDLE
//   mem_ready     - memory accepts the current beat
//   address       - registered word-aligned beat address
//   byte_en       - registered byte lanes for the current beat
//   mem_valid     - beat valid (BEAT0/BEAT1)
//   split         - current request needs two beats
//   done          - one-cycle completion pulse
//   misaligned    - one-cycle trap pulse (only when MISALIGN_TRAP_EN is defined)
//   sel_err       - one-cycle pulse when adr_src selects a non-existent source
//
// Build option: define MISALIGN_TRAP_EN to reject accesses whose offset is not a multiple of their size.

module mem_addr_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  input  logic [SEL_WIDTH-1:0]          adr_src,
  input  logic [1:0]                    req_size,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          mem_ready,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic [3:0]                    byte_en,
  output logic                          mem_valid,
  output logic                          split,
  output logic                          done,
  output logic                          misaligned,
  output logic                          sel_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t                  state;
  logic [2:0]              mask_hi;     // lanes spilling into the next word, used by BEAT1

  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_bad;
  logic [1:0]              off;
  logic [2:0]              nbytes;
  logic [3:0]              base_mask;
  logic [6:0]              mask;
  logic                    need_split;
  logic                    trap_hit;

  // Source mux; an out-of-range select falls through to address 0.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(adr_src) == i) begin
        sel_addr = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign sel_bad = (int'(adr_src) >= NUM_SRC);
  assign off     = sel_addr[1:0];

  always_comb begin
    nbytes    = 3'd4;
    base_mask = 4'b1111;
    case (req_size)
      2'd0: begin nbytes = 3'd1; base_mask = 4'b0001; end
      2'd1: begin nbytes = 3'd2; base_mask = 4'b0011; end
      default: begin nbytes = 3'd4; base_mask = 4'b1111; end
    endcase
  end

  // Lanes across two consecutive words: [3:0] this word, [6:4] the next one.
  assign mask       = {3'b000, base_mask} << off;
  assign need_split = (({1'b0, off} + nbytes) > 3'd4);

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;

  always_comb begin
    trap_hit = 1'b0;
    case (req_size)
      2'd0:    trap_hit = 1'b0;
      2'd1:    trap_hit = off[0];
      default: trap_hit = |off;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= req_valid && (state == IDLE) && trap_hit;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign trap_hit   = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      address   <= '0;
      byte_en   <= 4'b0000;
      mem_valid <= 1'b0;
      split     <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
      mask_hi   <= 3'b000;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel_err <= sel_bad;
            // A trapped request leaves the FSM and the beat outputs untouched.
            if (!trap_hit) begin
              state     <= BEAT0;
              address   <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
              byte_en   <= mask[3:0];
              mask_hi   <= mask[6:4];
              mem_valid <= 1'b1;
              split     <= need_split;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (split) begin
              state   <= BEAT1;
              address <= address + ADDR_WIDTH'(4);  // wraps at the top of the space
              byte_en <= {1'b0, mask_hi};
            end else begin
              state     <= IDLE;
              mem_valid <= 1'b0;
              split     <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            split     <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
          split     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Purpose: randomized self-checking bench for mem_addr_sequencer against a byte-level reference model.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: random mem_ready stalls per beat, junk requests injected while busy.

module tb_mem_addr_sequencer;

  localparam int AW = 32;
  localparam int NS = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS*AW-1:0] src_addr;
  logic [SW-1:0]   adr_src;
  logic [1:0]      req_size;
  logic            req_valid;
  logic            req_ready;
  logic            mem_ready;
  logic [AW-1:0]   address;
  logic [3:0]      byte_en;
  logic            mem_valid;
  logic            split;
  logic            done;
  logic            misaligned;
  logic            sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_addr_sequencer #(
    .ADDR_WIDTH (AW),
    .NUM_SRC    (NS),
    .SEL_WIDTH  (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src_addr   (src_addr),
    .adr_src    (adr_src),
    .req_size   (req_size),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_ready  (mem_ready),
    .address    (address),
    .byte_en    (byte_en),
    .mem_valid  (mem_valid),
    .split      (split),
    .done       (done),
    .misaligned (misaligned),
    .sel_err    (sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  // Scribble on inputs that the DUT must ignore while a transfer is in flight.
  task automatic junk_inputs();
    for (int i = 0; i < NS; i++) src_addr[i*AW +: AW] = $urandom;
    adr_src   = SW'($urandom_range(0, 3));
    req_size  = 2'($urandom_range(0, 3));
    req_valid = 1'($urandom_range(0, 1));
  endtask

  // One request from acceptance to done. Entered and left 1 unit after an edge with the DUT in IDLE.
  // Stall counts < 0 pick a random stall of 0..3 cycles for that beat.
  task automatic do_req(input logic [SW-1:0] sel, input logic [31:0] a_in, input logic [1:0] size,
                        input int st0, input int st1);
    logic [31:0] a, b, addr0, addr1;
    logic [29:0] w0;
    logic [3:0]  be0, be1;
    int          n, stalls, nbeats;
    bit          two, trap;

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    for (int i = 0; i < NS; i++) src_addr[i*AW +: AW] = $urandom;
    if (sel < NS) src_addr[sel*AW +: AW] = a_in;
    a = (sel < NS) ? a_in : 32'd0;

    // Reference: walk each byte of the access and file it under its word.
    n     = size_bytes(size);
    w0    = a[31:2];
    be0   = 4'b0000;
    be1   = 4'b0000;
    for (int i = 0; i < n; i++) begin
      b = a + 32'(i);
      if (b[31:2] == w0) be0[b[1:0]] = 1'b1;
      else               be1[b[1:0]] = 1'b1;
    end
    addr0  = {w0, 2'b00};
    addr1  = addr0 + 32'd4;
    two    = (be1 != 4'b0000);
    nbeats = two ? 2 : 1;
    trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = ((a % 32'(n)) != 0);
`endif

    adr_src   = sel;
    req_size  = size;
    req_valid = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    tick();
    req_valid = 1'b0;

    chk("sel_err_pulse", 32'(sel_err), 32'(sel >= NS));
    chk("misaligned_pulse", 32'(misaligned), 32'(trap));
    if (trap) begin
      chk("trap_mem_valid", 32'(mem_valid), 32'd0);
      chk("trap_req_ready", 32'(req_ready), 32'd1);
      chk("trap_done", 32'(done), 32'd0);
      return;
    end

    for (int k = 0; k < nbeats; k++) begin
      stalls = (k == 0) ? st0 : st1;
      if (stalls < 0) stalls = $urandom_range(0, 3);
      for (int s = 0; s <= stalls; s++) begin
        chk("mem_valid", 32'(mem_valid), 32'd1);
        chk(k == 0 ? "beat0_addr" : "beat1_addr", address, k == 0 ? addr0 : addr1);
        chk(k == 0 ? "beat0_be" : "beat1_be", 32'(byte_en), 32'(k == 0 ? be0 : be1));
        chk("split", 32'(split), 32'(two));
        chk("done_busy", 32'(done), 32'd0);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (k > 0 || s > 0) chk("sel_err_once", 32'(sel_err), 32'd0);
        junk_inputs();
        mem_ready = (s == stalls);
        tick();
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("mem_valid_end", 32'(mem_valid), 32'd0);
    chk("split_cleared", 32'(split), 32'd0);
    chk("req_ready_done", 32'(req_ready), 32'd1);
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      req_valid = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_mem_valid", 32'(mem_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    reset     = 1'b1;
    src_addr  = '0;
    adr_src   = '0;
    req_size  = 2'd0;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_address", address, 32'd0);
    chk("rst_byte_en", 32'(byte_en), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_split", 32'(split), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed cases from the plan.
    do_req(2'd0, 32'h0000_0001, 2'd2, -1, -1);
    idle_cycles(1);
    do_req(2'd1, 32'h0000_0010, 2'd2, 0, 0);
    do_req(2'd2, 32'h0000_0013, 2'd1, 3, 0);
    do_req(2'd0, 32'hFFFF_FFFF, 2'd0, 1, 0);
    do_req(2'd1, 32'hFFFF_FFFF, 2'd1, 0, 2);
    do_req(2'd3, 32'h1234_5677, 2'd2, -1, -1);
    idle_cycles(2);

    // Reset in the middle of a transfer abandons it without a done pulse.
    adr_src   = 2'd0;
    req_valid = 1'b1;
`ifdef MISALIGN_TRAP_EN
    src_addr[0 +: AW] = 32'h0000_0010;
    req_size  = 2'd2;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b0;
    chk("pre_rst_addr", address, 32'h0000_0010);
`else
    src_addr[0 +: AW] = 32'h0000_0013;
    req_size  = 2'd1;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("pre_rst_addr", address, 32'h0000_0014);
`endif
    chk("pre_rst_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_address", address, 32'd0);
    tick();
    chk("post_rst_done", 32'(done), 32'd0);

    // Back-to-back: second request is accepted in the done cycle of the first.
    do_req(2'd1, 32'h0000_0010, 2'd2, 0, 0);
    do_req(2'd0, 32'h0000_0022, 2'd2, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2:       ra = 32'($urandom_range(0, 15));
        default: ra = $urandom;
      endcase
      do_req(SW'($urandom_range(0, 3)), ra, 2'($urandom_range(0, 3)), -1, -1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
